// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue for the pipeline front end.
// This block issues one sequential 32-bit fetch at a time to instruction memory.
// Each returned {pc, instr} pair is stored in a small FIFO, and the head entry
// is presented to IF/ID with first-word fall-through.
// A taken branch (redirect) flushes the FIFO and steers fetch to the branch
// target. A response that is still in flight when the redirect arrives is
// dropped when it returns.

module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect,
   input  logic [63:0]                redirect_pc,
   input  logic                       deq,
   output logic                       out_valid,
   output logic [31:0]                out_instr,
   output logic [63:0]                out_pc,
   output logic                       mem_req,
   output logic [63:0]                mem_addr,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   input  logic [31:0]                mem_rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int            PW        = $clog2(DEPTH);
   localparam int            CW        = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [63:0]   WORD_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   fetch_state_t  state;
   logic [63:0]   fetch_pc;
   logic [63:0]   req_pc;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [63:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic          push;
   logic          pop;
   logic          issue;

   // A request is raised only when all of these hold: the block is idle, the
   // FIFO has room, and no redirect is pending. Gating with reset keeps the
   // port quiet while reset is asserted.
   always_comb begin
      mem_req = reset && (state == IDLE) && (count < FULL_CNT) && !redirect;
   end

   // Push and pop qualifiers. A redirect overrides both of them.
   always_comb begin
      issue = mem_req && mem_gnt;
      push  = (state == WAIT) && mem_rvalid && !redirect;
      pop   = deq && out_valid && !redirect;
   end

   // The head entry falls through to IF/ID. When the FIFO is empty, a NOP bubble
   // is presented instead.
   always_comb begin
      out_valid = (count != '0);
      out_instr = NOP;
      out_pc    = '0;
      if (out_valid) begin
         out_instr = instr_mem[rd_ptr];
         out_pc    = pc_mem[rd_ptr];
      end
   end

   assign mem_addr = fetch_pc;

   // Fetch state machine, FIFO pointers and occupancy.
   // The redirect branch is evaluated first so that it wins over everything else.
   // A response that arrives in the same cycle as a redirect is consumed and
   // dropped, so the FSM returns to IDLE instead of waiting for a second response
   // that will never come.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fetch_pc <= redirect_pc & WORD_MASK;
         case (state)
            WAIT:    state <= mem_rvalid ? IDLE : DISCARD;
            DISCARD: state <= mem_rvalid ? IDLE : DISCARD;
            default: state <= IDLE;
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + 64'd4;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) state <= IDLE;
            end
            DISCARD: begin
               if (mem_rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage. Stale slots are never read, because out_valid masks them, so
   // the storage needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= req_pc;
         instr_mem[wr_ptr] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue.
// The bench drives a randomised memory responder. Every cycle it compares the
// DUT outputs against a queue-based reference model of the fetch queue.

module tb_inst_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        deq;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [2:0]  count;

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0), .NOP(NOP)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .deq(deq), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .count(count)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      model_q[$];
   logic [63:0] next_fetch;
   bit          pending;
   bit          pend_drop;
   logic [63:0] pend_pc;
   int          resp_wait;
   int          pushes;

   int lat_min, lat_max, gnt_pct;
   bit gnt_always, deq_random, deq_level;
   int total, passed, failed, cyc;

   function automatic bit expReq();
      return reset && !pending && (model_q.size() < DEPTH) && !redirect;
   endfunction

   task automatic modelReset();
      model_q.delete();
      next_fetch = 64'h0;
      pending    = 0;
      pend_drop  = 0;
      resp_wait  = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic applyStimulus();
      redirect    = 1'b0;
      redirect_pc = 64'h0;
      deq         = deq_random ? 1'($urandom_range(1, 0)) : deq_level;
      mem_gnt     = gnt_always ? 1'b1 : 1'($urandom_range(99, 0) < gnt_pct);
      mem_rdata   = $urandom;
      mem_rvalid  = pending && (resp_wait == 0);
      if (pending && resp_wait > 0) resp_wait--;
   endtask

   task automatic checkAll();
      checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         checkOutput("out_pc", out_pc, model_q[0].pc);
         checkOutput("out_instr", 64'(out_instr), 64'(model_q[0].instr));
      end else begin
         checkOutput("out_pc_empty", out_pc, 64'h0);
         checkOutput("out_instr_empty", 64'(out_instr), 64'(NOP));
      end
      checkOutput("count", 64'(count), 64'(model_q.size()));
      checkOutput("mem_req", 64'(mem_req), 64'(expReq()));
      checkOutput("mem_addr", mem_addr, next_fetch);
   endtask

   // Advance the reference model by one clock edge, using the inputs the bench drove.
   task automatic modelStep();
      bit req;
      if (!reset) begin
         modelReset();
         return;
      end
      req = expReq();
      if (redirect) begin
         model_q.delete();
         if (pending && mem_rvalid) pending = 0;
         else if (pending)          pend_drop = 1;
         next_fetch = {redirect_pc[63:2], 2'b00};
      end else begin
         if (deq && model_q.size() > 0) void'(model_q.pop_front());
         if (pending && mem_rvalid) begin
            if (!pend_drop) begin
               model_q.push_back('{pc: pend_pc, instr: mem_rdata});
               pushes++;
            end
            pending = 0;
         end
         if (req && mem_gnt) begin
            pending    = 1;
            pend_drop  = 0;
            pend_pc    = next_fetch;
            next_fetch = next_fetch + 64'd4;
            resp_wait  = $urandom_range(lat_max, lat_min);
         end
      end
   endtask

   task automatic clockModel();
      @(posedge clk);
      modelStep();
      cyc++;
      #1;
   endtask

   task automatic cycle();
      applyStimulus();
      #1;
      checkAll();
      clockModel();
   endtask

   // Directed scenarios followed by a randomised soak, all checked against the model.
   initial begin
      int          grant_cycle, first_valid, max_cnt;
      logic [63:0] exp_seq, saved_addr;
      bit          done, got_req, got_valid;

      total = 0; passed = 0; failed = 0; cyc = 0; pushes = 0;
      lat_min = 0; lat_max = 0; gnt_pct = 100;
      gnt_always = 1; deq_random = 0; deq_level = 1;
      reset = 1'b0; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      modelReset();

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #1;
      checkAll();
      reset = 1'b1;

      // Scenario 1: sequential fetch with 1-cycle memory and deq held high.
      $display("[TB] sequential fetch");
      grant_cycle = -1; first_valid = -1; exp_seq = 64'h0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         if (grant_cycle < 0 && expReq() && mem_gnt) grant_cycle = cyc;
         #1;
         checkAll();
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && deq) begin
            checkOutput("seq_pc", out_pc, exp_seq);
            exp_seq = exp_seq + 64'd4;
         end
         clockModel();
      end
      checkOutput("first_valid_latency", 64'(first_valid - grant_cycle), 64'd2);

      // Scenario 2: fill the FIFO, then free one slot.
      $display("[TB] fill to full");
      deq_level = 0;
      repeat (12) cycle();
      applyStimulus();
      #1;
      checkAll();
      checkOutput("full_count", 64'(count), 64'(DEPTH));
      checkOutput("full_no_req", 64'(mem_req), 64'd0);
      saved_addr = next_fetch;
      clockModel();
      applyStimulus();
      deq = 1'b1;
      #1;
      checkAll();
      clockModel();
      applyStimulus();
      #1;
      checkAll();
      checkOutput("count_after_deq", 64'(count), 64'd3);
      checkOutput("req_after_deq", 64'(mem_req), 64'd1);
      checkOutput("addr_after_deq", mem_addr, saved_addr);
      clockModel();

      // Scenario 3: redirect while a response is still outstanding.
      $display("[TB] redirect in WAIT");
      deq_level = 1; lat_min = 2; lat_max = 2; done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         applyStimulus();
         if (pending && !mem_rvalid) begin
            redirect = 1'b1;
            redirect_pc = 64'h103;
            done = 1;
         end
         #1;
         checkAll();
         clockModel();
      end
      checkOutput("redirect_window_found", 64'(done), 64'd1);
      got_req = 0; got_valid = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus();
         #1;
         checkAll();
         if (!got_req && mem_req) begin
            checkOutput("redirect_addr", mem_addr, 64'h100);
            got_req = 1;
         end
         if (!got_valid && out_valid) begin
            checkOutput("redirect_first_pc", out_pc, 64'h100);
            got_valid = 1;
         end
         clockModel();
      end
      checkOutput("redirect_progress", 64'({got_req, got_valid}), 64'd3);

      // Scenario 4: redirect, deq and rvalid together with two entries queued.
      $display("[TB] redirect with push and pop");
      deq_level = 0; lat_min = 0; lat_max = 0;
      applyStimulus();
      redirect = 1'b1;
      redirect_pc = 64'h200;
      #1;
      checkAll();
      clockModel();
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         applyStimulus();
         if (model_q.size() == 2 && mem_rvalid) begin
            redirect = 1'b1;
            redirect_pc = 64'h300;
            deq = 1'b1;
            done = 1;
         end
         #1;
         checkAll();
         clockModel();
      end
      checkOutput("flush_window_found", 64'(done), 64'd1);
      applyStimulus();
      #1;
      checkAll();
      checkOutput("flush_count", 64'(count), 64'd0);
      checkOutput("flush_valid", 64'(out_valid), 64'd0);
      clockModel();

      // Scenario 5: asynchronous reset while a fetch is outstanding.
      $display("[TB] async reset in WAIT");
      lat_min = 3; lat_max = 3; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle();
         if (pending && model_q.size() > 0) done = 1;
      end
      checkOutput("wait_state_reached", 64'(done), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("areset_valid", 64'(out_valid), 64'd0);
      checkOutput("areset_instr", 64'(out_instr), 64'(NOP));
      checkOutput("areset_pc", out_pc, 64'h0);
      checkOutput("areset_req", 64'(mem_req), 64'd0);
      checkOutput("areset_count", 64'(count), 64'd0);
      checkOutput("areset_addr", mem_addr, 64'h0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      gnt_always = 0; gnt_pct = 0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         if (k == 2) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
         end
         #1;
         checkAll();
         clockModel();
      end
      applyStimulus();
      #1;
      checkOutput("late_rvalid_no_push", 64'(count), 64'd0);
      clockModel();

      // Scenario 6: randomised soak with random deq, grant, latency, stray
      // responses and occasional redirects.
      $display("[TB] random soak");
      deq_random = 1; gnt_pct = 70; lat_min = 0; lat_max = 3; max_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus();
         if (!pending && $urandom_range(9, 0) == 0) mem_rvalid = 1'b1;
         if ($urandom_range(39, 0) == 0) begin
            redirect = 1'b1;
            redirect_pc = {32'h0, $urandom};
         end
         #1;
         checkAll();
         if (int'(count) > max_cnt) max_cnt = int'(count);
         clockModel();
      end
      checkOutput("max_count_le_depth", 64'(max_cnt <= DEPTH), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
